// File: rtl/blitter_ctrl.sv
// blitter_ctrl: DMA-style word copier that borrows the memory bus from the CPU
// via a hold/hold_ack handshake, copies in bursts of up to MAX_BURST words
// (one READ cycle plus one WRITE cycle per word), and gives the bus back to
// the CPU between bursts and once the copy is complete.
//
// Handshake: hold is a registered request. The block owns the bus only while
// hold_ack is high. It drops hold in YIELD/RELEASE and waits for hold_ack to
// fall before requesting again or signalling done.
module blitter_ctrl #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] src_addr,
    input  logic [11:0] dst_addr,
    input  logic [11:0] length,
    output logic        busy,
    output logic        done,
    output logic        hold,
    input  logic        hold_ack,
    output logic        bus_sel,
    output logic [11:0] mem_address,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        memwt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        YIELD   = 3'd4,
        RELEASE = 3'd5
    } state_t;

    // Burst counter value seen in the last WRITE of a burst.
    localparam logic [11:0] BURST_LAST = 12'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [11:0] src_q, src_d;
    logic [11:0] dst_q, dst_d;
    logic [11:0] count_q, count_d;
    logic [11:0] burst_q, burst_d;
    logic [15:0] buffer_q, buffer_d;
    logic        hold_q, hold_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bus_sel_q, bus_sel_d;
    logic        memwt_q, memwt_d;
    logic [11:0] mem_address_q, mem_address_d;

    // Next state, address/count bookkeeping and the done pulse.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        count_d  = count_q;
        burst_d  = burst_q;
        buffer_d = buffer_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != 12'd0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        count_d = length;
                        burst_d = 12'd0;
                        state_d = REQ;
                    end else begin
                        // Nothing to copy: complete immediately without the bus.
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (hold_ack) begin
                    state_d = READ;
                end
            end
            READ: begin
                buffer_d = mem_data_in;
                src_d    = src_q + 12'd1;
                state_d  = WRITE;
            end
            WRITE: begin
                dst_d   = dst_q + 12'd1;
                count_d = count_q - 12'd1;
                burst_d = burst_q + 12'd1;
                if (count_q == 12'd1) begin
                    state_d = RELEASE;
                end else if (burst_q == BURST_LAST) begin
                    burst_d = 12'd0;
                    state_d = YIELD;
                end else begin
                    state_d = READ;
                end
            end
            YIELD: begin
                // Let the CPU take the bus back before asking again.
                if (!hold_ack) begin
                    state_d = REQ;
                end
            end
            RELEASE: begin
                if (!hold_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs derived from the state being entered, so they line up with it.
    always_comb begin
        hold_d        = (state_d == REQ) || (state_d == READ) || (state_d == WRITE);
        busy_d        = (state_d != IDLE);
        bus_sel_d     = (state_d == READ) || (state_d == WRITE);
        memwt_d       = (state_d == WRITE);
        mem_address_d = 12'd0;
        if (state_d == READ) begin
            mem_address_d = src_d;
        end else if (state_d == WRITE) begin
            mem_address_d = dst_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            src_q         <= 12'd0;
            dst_q         <= 12'd0;
            count_q       <= 12'd0;
            burst_q       <= 12'd0;
            buffer_q      <= 16'd0;
            hold_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            bus_sel_q     <= 1'b0;
            memwt_q       <= 1'b0;
            mem_address_q <= 12'd0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            count_q       <= count_d;
            burst_q       <= burst_d;
            buffer_q      <= buffer_d;
            hold_q        <= hold_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            bus_sel_q     <= bus_sel_d;
            memwt_q       <= memwt_d;
            mem_address_q <= mem_address_d;
        end
    end

    assign hold         = hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign bus_sel      = bus_sel_q;
    assign memwt        = memwt_q;
    assign mem_address  = mem_address_q;
    assign mem_data_out = buffer_q;

endmodule

// File: tb/tb_blitter_ctrl.sv
// tb_blitter_ctrl: drives copies into blitter_ctrl (MAX_BURST=4) against a
// behavioural memory and a CPU that answers hold with a configurable delay.
// Expected memory contents come from a word-by-word copy model of the array.
module tb_blitter_ctrl;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [11:0] length;
    logic        busy;
    logic        done;
    logic        hold;
    logic        hold_ack;
    logic        bus_sel;
    logic [11:0] mem_address;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        memwt;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic        mem_init;
    int          mem_seed;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ack_delay = 0;
    int wait_cnt;

    // Results gathered by run_copy
    logic [11:0] wr_q[$];
    logic [11:0] rd_q[$];
    int          burst_q[$];
    logic [11:0] exp_q[$];
    int          n_done, done_cyc, ack_fall_cyc, n_viol, n_ack_bad, timeout;
    logic        first_busy;

    blitter_ctrl #(.MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .hold         (hold),
        .hold_ack     (hold_ack),
        .bus_sel      (bus_sel),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .memwt        (memwt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pattern(input int i);
        return 16'((i * 40503) ^ mem_seed ^ (i >> 4));
    endfunction

    // Memory: combinational read, write on the edge where memwt is high.
    assign mem_data_in = mem[mem_address];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pattern(i);
        end else if (memwt && bus_sel) begin
            mem[mem_address] <= mem_data_out;
        end
    end

    // CPU: hold_ack follows hold after 1 + ack_delay cycles.
    always @(posedge clk) begin
        if (rst) begin
            hold_ack <= 1'b0;
            wait_cnt <= 0;
        end else if (hold !== hold_ack) begin
            if (wait_cnt >= ack_delay) begin
                hold_ack <= hold;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- reference model ----------------
    task automatic ref_copy(input logic [11:0] s, input logic [11:0] d, input int l);
        logic [11:0] a, b;
        for (int i = 0; i < l; i++) begin
            a = s + 12'(i);
            b = d + 12'(i);
            ref_mem[b] = ref_mem[a];
        end
    endtask

    function automatic int mem_diffs();
        int c;
        c = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) c++;
        return c;
    endfunction

    // ---------------- driver ----------------
    // Issues one start and observes the transfer until a few cycles past done.
    // poke != 0 re-pulses start with different operands every poke cycles while busy.
    task automatic run_copy(input logic [11:0] s, input logic [11:0] d,
                            input logic [11:0] l, input int poke);
        int   words, post;
        logic hold_prev, ack_prev;
        bit   finished;
        wr_q.delete(); rd_q.delete(); burst_q.delete();
        n_done = 0; done_cyc = -1; ack_fall_cyc = -100;
        n_viol = 0; n_ack_bad = 0; timeout = 0;
        words = 0; post = 0; hold_prev = 1'b0; ack_prev = 1'b0; finished = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_busy = busy;
        for (int k = 0; k < 3000; k++) begin
            if (k > 0) @(negedge clk);
            if (memwt) begin
                wr_q.push_back(mem_address);
                words++;
            end
            if (bus_sel && !memwt) rd_q.push_back(mem_address);
            if (memwt && !bus_sel) n_viol++;
            if (hold && !hold_prev && hold_ack) n_ack_bad++;
            if (!hold && hold_prev) begin
                burst_q.push_back(words);
                words = 0;
            end
            if (ack_prev && !hold_ack) ack_fall_cyc = cyc;
            if (n_done == 0 && !done && !busy) n_viol++;
            if (done && busy) n_viol++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            hold_prev = hold;
            ack_prev  = hold_ack;
            if (n_done > 0) begin
                post++;
                if (post > 4) begin
                    finished = 1;
                    break;
                end
            end
            if (poke != 0 && n_done == 0 && (k % poke) == poke - 1) begin
                src_addr = s ^ 12'h0A5;
                dst_addr = 12'hE00;
                length   = 12'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!finished) timeout = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        mem_seed = int'($urandom);
        mem_init = 1'b1;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", done); end
        n_vec++; if (hold !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %b need 0", hold); end
        n_vec++; if (bus_sel !== 1'b0) begin n_err++; $display("FAIL reset_bus_sel: got %b need 0", bus_sel); end
        n_vec++; if (memwt !== 1'b0) begin n_err++; $display("FAIL reset_memwt: got %b need 0", memwt); end
        n_vec++; if (mem_address !== 12'd0) begin n_err++; $display("FAIL reset_addr: got %h need 000", mem_address); end
        n_vec++; if (mem_data_out !== 16'd0) begin n_err++; $display("FAIL reset_data: got %h need 0000", mem_data_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bad;
        ack_delay = 0;
        ref_copy(12'h100, 12'h200, 3);
        run_copy(12'h100, 12'h200, 12'd3, 0);
        n_vec++; if (timeout != 0) begin n_err++; $display("FAIL basic_timeout: no done within budget"); end
        n_vec++; if (first_busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b need 1 after start", first_busy); end
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL basic_done_count: got %0d need 1", n_done); end
        n_vec++; if (wr_q.size() != 3) begin n_err++; $display("FAIL basic_memwt_pulses: got %0d need 3", wr_q.size()); end
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(12'h200 + 12'(i));
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) if (wr_q[i] !== exp_q[i]) bad = 1;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL basic_wr_addrs: got %0d writes, first %h need 200..202", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 12'hxxx); end
        n_vec++; if (done_cyc != ack_fall_cyc + 1) begin n_err++; $display("FAIL basic_done_timing: done at %0d need %0d", done_cyc, ack_fall_cyc + 1); end
        n_vec++; if (n_viol != 0) begin n_err++; $display("FAIL basic_protocol: got %0d violations need 0", n_viol); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL basic_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_zero_len();
        int bad;
        bad = 0;
        @(negedge clk);
        src_addr = 12'h123; dst_addr = 12'h456; length = 12'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b need 1", done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b need 0", busy); end
        for (int k = 0; k < 6; k++) begin
            if (hold !== 1'b0 || busy !== 1'b0) bad++;
            if (k > 0 && done !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL zero_quiet: got %0d bad cycles need 0", bad); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL zero_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_burst();
        int bad;
        ack_delay = 0;
        ref_copy(12'h500, 12'h600, 10);
        run_copy(12'h500, 12'h600, 12'd10, 0);
        bad = (burst_q.size() != 3) ? 1 : 0;
        if (burst_q.size() == 3 && (burst_q[0] != 4 || burst_q[1] != 4 || burst_q[2] != 2)) bad = 1;
        n_vec++; if (timeout != 0) begin n_err++; $display("FAIL burst_timeout: no done within budget"); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL burst_split: got %0d tenures (first %0d) need 4,4,2", burst_q.size(), (burst_q.size() > 0) ? burst_q[0] : -1); end
        n_vec++; if (n_ack_bad != 0) begin n_err++; $display("FAIL burst_ack_gap: got %0d re-requests with hold_ack high need 0", n_ack_bad); end
        n_vec++; if (wr_q.size() != 10) begin n_err++; $display("FAIL burst_words: got %0d need 10", wr_q.size()); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL burst_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_wrap();
        int bad_r, bad_w;
        logic [11:0] rd_exp[4];
        logic [11:0] wr_exp[4];
        rd_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        wr_exp = '{12'h7FF, 12'h800, 12'h801, 12'h802};
        ack_delay = 1;
        ref_copy(12'hFFE, 12'h7FF, 4);
        run_copy(12'hFFE, 12'h7FF, 12'd4, 0);
        bad_r = (rd_q.size() != 4) ? 1 : 0;
        bad_w = (wr_q.size() != 4) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            if (i < rd_q.size() && rd_q[i] !== rd_exp[i]) bad_r = 1;
            if (i < wr_q.size() && wr_q[i] !== wr_exp[i]) bad_w = 1;
        end
        n_vec++; if (bad_r != 0) begin n_err++; $display("FAIL wrap_reads: got %0d reads, third %h need FFE,FFF,000,001", rd_q.size(), (rd_q.size() > 2) ? rd_q[2] : 12'hxxx); end
        n_vec++; if (bad_w != 0) begin n_err++; $display("FAIL wrap_writes: got %0d writes, last %h need 7FF..802", wr_q.size(), (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : 12'hxxx); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL wrap_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_reset_mid();
        int n, bad;
        bit hit;
        n = 0; hit = 0; bad = 0;
        ack_delay = 0;
        @(negedge clk);
        src_addr = 12'h300; dst_addr = 12'h400; length = 12'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k > 0) @(negedge clk);
            if (memwt) n++;
            if (n == 2) begin
                hit = 1;
                break;
            end
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL rstmid_reach: got %0d writes need 2", n); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (hold !== 1'b0) begin n_err++; $display("FAIL rstmid_hold: got %b need 0", hold); end
        n_vec++; if (busy !== 1'b0 || bus_sel !== 1'b0 || memwt !== 1'b0) begin n_err++; $display("FAIL rstmid_outs: got busy %b bus_sel %b memwt %b need 0", busy, bus_sel, memwt); end
        for (int k = 0; k < 6; k++) begin
            if (done !== 1'b0 || hold !== 1'b0) bad++;
            @(negedge clk);
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d bad cycles need 0", bad); end
        // The second word is written on the same edge that samples rst.
        ref_copy(12'h300, 12'h400, 2);
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL rstmid_partial_mem: got %0d bad words need 0", mem_diffs()); end
        ref_copy(12'h300, 12'h400, 5);
        run_copy(12'h300, 12'h400, 12'd5, 0);
        n_vec++; if (n_done != 1 || timeout != 0) begin n_err++; $display("FAIL rstmid_restart_done: got %0d dones need 1", n_done); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL rstmid_restart_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_start_while_busy();
        int bad;
        ack_delay = 2;
        ref_copy(12'h700, 12'h900, 9);
        run_copy(12'h700, 12'h900, 12'd9, 3);
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(12'h900 + 12'(i));
        bad = (wr_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) if (wr_q[i] !== exp_q[i]) bad = 1;
        n_vec++; if (n_done != 1 || timeout != 0) begin n_err++; $display("FAIL busy_start_done: got %0d dones need 1", n_done); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL busy_start_addrs: got %0d writes need 9 at 900..908", wr_q.size()); end
        n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL busy_start_mem: got %0d bad words need 0", mem_diffs()); end
    endtask

    task automatic test_random();
        logic [11:0] s, d;
        int l, rem, bad;
        for (int it = 0; it < 8; it++) begin
            s = 12'($urandom);
            d = 12'($urandom);
            l = int'($urandom_range(1, 20));
            ack_delay = int'($urandom_range(0, 3));
            ref_copy(s, d, l);
            run_copy(s, d, 12'(l), 0);
            bad = 0;
            rem = l;
            for (int b = 0; rem > 0; b++) begin
                if (b >= burst_q.size() || burst_q[b] != ((rem > MB) ? MB : rem)) bad = 1;
                rem = rem - MB;
            end
            if (burst_q.size() != (l + MB - 1) / MB) bad = 1;
            n_vec++; if (n_done != 1 || timeout != 0) begin n_err++; $display("FAIL rand%0d_done: got %0d dones need 1", it, n_done); end
            n_vec++; if (wr_q.size() != l) begin n_err++; $display("FAIL rand%0d_words: got %0d need %0d", it, wr_q.size(), l); end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL rand%0d_bursts: got %0d tenures need %0d", it, burst_q.size(), (l + MB - 1) / MB); end
            n_vec++; if (n_viol != 0 || n_ack_bad != 0) begin n_err++; $display("FAIL rand%0d_protocol: got %0d/%0d violations need 0", it, n_viol, n_ack_bad); end
            n_vec++; if (done_cyc != ack_fall_cyc + 1) begin n_err++; $display("FAIL rand%0d_done_timing: done at %0d need %0d", it, done_cyc, ack_fall_cyc + 1); end
            n_vec++; if (mem_diffs() != 0) begin n_err++; $display("FAIL rand%0d_mem: got %0d bad words need 0 (src %h dst %h len %0d)", it, mem_diffs(), s, d, l); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        mem_init = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_burst();
        test_wrap();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
